// File: rtl/fb_loader_pkg.sv
// fb_loader_pkg: default widths, FSM state encodings and a sizing helper
// shared by fb_loader and its read-issue sub-block.
// No ports; imported with `import fb_loader_pkg::*`.
package fb_loader_pkg;

  localparam int DEF_W_CHANNEL = 8;
  localparam int DEF_W_ADDR    = 24;
  localparam int DEF_W_DATA    = 32;
  localparam int DEF_W_FB_ADDR = 10;
  localparam int DEF_K_WORDS   = 9;
  localparam int DEF_MAX_OUTST = 4;

  typedef enum logic [1:0] {
    FB_IDLE  = 2'd0,
    FB_FETCH = 2'd1,
    FB_DONE  = 2'd2
  } fb_state_t;

  // Counter width able to hold 0..max_outst inclusive.
  function automatic int outst_width(input int max_outst);
    return $clog2(max_outst) + 1;
  endfunction

endpackage

// File: rtl/fb_rd_issue.sv
// fb_rd_issue: read-address generator and outstanding-request credit counter.
// Ports: cap/cap_base start a new tile; active_nx/total_nx give the next-cycle
// fetch window; rd_req_* is the address channel; beat flags an accepted data word.
module fb_rd_issue
  import fb_loader_pkg::*;
#(
  parameter int W_ADDR    = DEF_W_ADDR,
  parameter int W_CNT     = DEF_W_CHANNEL + 4,
  parameter int MAX_OUTST = DEF_MAX_OUTST
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cap,
  input  logic [W_ADDR-1:0] cap_base,
  input  logic              active_nx,
  input  logic [W_CNT-1:0]  total_nx,
  input  logic              rd_req_ready,
  input  logic              rd_data_valid,
  output logic              rd_req_valid,
  output logic [W_ADDR-1:0] rd_addr,
  output logic              beat
);

  localparam int W_OUT = outst_width(MAX_OUTST);

  logic [W_ADDR-1:0] base, base_nx;
  logic [W_CNT-1:0]  issued, issued_nx;
  logic [W_OUT-1:0]  outst, outst_nx;
  logic              fire;

  assign fire = rd_req_valid & rd_req_ready;
  // Data with nothing in flight cannot belong to us; drop it.
  assign beat = rd_data_valid & (outst != '0);

  always_comb begin
    base_nx   = cap ? cap_base : base;
    issued_nx = cap ? '0 : issued + W_CNT'(fire);
    outst_nx  = outst + W_OUT'(fire) - W_OUT'(beat);
  end

  // valid/addr are registered from next-state values so they hold steady
  // while stalled: issued cannot move and outst can only fall without a fire.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      base         <= '0;
      issued       <= '0;
      outst        <= '0;
      rd_req_valid <= 1'b0;
      rd_addr      <= '0;
    end else begin
      base         <= base_nx;
      issued       <= issued_nx;
      outst        <= outst_nx;
      rd_req_valid <= active_nx && (issued_nx < total_nx) &&
                      (outst_nx < W_OUT'(MAX_OUTST));
      rd_addr      <= base_nx + W_ADDR'(issued_nx);
    end
  end

endmodule

// File: rtl/fb_loader.sv
// fb_loader: on a load pulse, fetches one output-channel weight tile over a split
// read interface and writes it sequentially into the filter buffer; pulses done.
// Ports: q_* config, i_load_req/i_chn_out request, rd_* memory, fb_* SRAM write,
// o_busy/o_load_done/o_req_drop status. FB_LOAD_CHECKSUM_EN adds o_checksum.
module fb_loader
  import fb_loader_pkg::*;
#(
  parameter int W_CHANNEL = DEF_W_CHANNEL,
  parameter int W_ADDR    = DEF_W_ADDR,
  parameter int W_DATA    = DEF_W_DATA,
  parameter int W_FB_ADDR = DEF_W_FB_ADDR,
  parameter int K_WORDS   = DEF_K_WORDS,
  parameter int MAX_OUTST = DEF_MAX_OUTST
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [W_CHANNEL-1:0] q_channel,
  input  logic [W_ADDR-1:0]    q_filter_base,
  input  logic                 i_load_req,
  input  logic [W_CHANNEL-1:0] i_chn_out,
  output logic                 o_rd_req_valid,
  input  logic                 i_rd_req_ready,
  output logic [W_ADDR-1:0]    o_rd_addr,
  input  logic                 i_rd_data_valid,
  input  logic [W_DATA-1:0]    i_rd_data,
  output logic                 o_fb_we,
  output logic [W_FB_ADDR-1:0] o_fb_addr,
  output logic [W_DATA-1:0]    o_fb_wdata,
  output logic                 o_busy,
  output logic                 o_load_done,
  output logic                 o_req_drop
`ifdef FB_LOAD_CHECKSUM_EN
  ,
  output logic [W_DATA-1:0]    o_checksum
`endif
);

  localparam int W_T = W_CHANNEL + 4;

  fb_state_t         state;
  logic [W_T-1:0]    total, received;
  logic [W_T-1:0]    cap_total, total_nx;
  logic [W_ADDR-1:0] cap_base;
  logic              cap, active_nx, beat;

  assign cap       = (state == FB_IDLE) && i_load_req;
  assign cap_total = W_T'(q_channel) * W_T'(K_WORDS);
  assign cap_base  = q_filter_base + W_ADDR'(i_chn_out) * W_ADDR'(cap_total);
  assign total_nx  = cap ? cap_total : total;
  // Fetching continues next cycle unless the final write is going out now.
  assign active_nx = cap || ((state == FB_FETCH) && (received != total));

  fb_rd_issue #(
    .W_ADDR   (W_ADDR),
    .W_CNT    (W_T),
    .MAX_OUTST(MAX_OUTST)
  ) u_rd_issue (
    .clk          (clk),
    .rstn         (rstn),
    .cap          (cap),
    .cap_base     (cap_base),
    .active_nx    (active_nx),
    .total_nx     (total_nx),
    .rd_req_ready (i_rd_req_ready),
    .rd_data_valid(i_rd_data_valid),
    .rd_req_valid (o_rd_req_valid),
    .rd_addr      (o_rd_addr),
    .beat         (beat)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= FB_IDLE;
      total       <= '0;
      received    <= '0;
      o_fb_we     <= 1'b0;
      o_fb_addr   <= '0;
      o_fb_wdata  <= '0;
      o_busy      <= 1'b0;
      o_load_done <= 1'b0;
      o_req_drop  <= 1'b0;
`ifdef FB_LOAD_CHECKSUM_EN
      o_checksum  <= '0;
`endif
    end else begin
      o_fb_we     <= 1'b0;
      o_load_done <= 1'b0;
      // Requests in FETCH or in the done cycle are lost; remember that.
      if (i_load_req && (state != FB_IDLE)) o_req_drop <= 1'b1;
      case (state)
        FB_IDLE: begin
          if (i_load_req) begin
            state    <= FB_FETCH;
            total    <= cap_total;
            received <= '0;
            o_busy   <= 1'b1;
`ifdef FB_LOAD_CHECKSUM_EN
            o_checksum <= '0;
`endif
          end
        end
        FB_FETCH: begin
          if (beat) begin
            o_fb_we    <= 1'b1;
            o_fb_addr  <= W_FB_ADDR'(received);
            o_fb_wdata <= i_rd_data;
            received   <= received + 1'b1;
`ifdef FB_LOAD_CHECKSUM_EN
            o_checksum <= o_checksum + i_rd_data;
`endif
          end
          if (received == total) begin
            state       <= FB_DONE;
            o_load_done <= 1'b1;
          end
        end
        FB_DONE: begin
          state  <= FB_IDLE;
          o_busy <= 1'b0;
        end
        default: state <= FB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_loader.sv
module tb_fb_loader;

  localparam int MAX_OUTST = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic [7:0]  q_channel;
  logic [23:0] q_filter_base;
  logic        i_load_req;
  logic [7:0]  i_chn_out;
  logic        o_rd_req_valid;
  logic        i_rd_req_ready;
  logic [23:0] o_rd_addr;
  logic        i_rd_data_valid;
  logic [31:0] i_rd_data;
  logic        o_fb_we;
  logic [9:0]  o_fb_addr;
  logic [31:0] o_fb_wdata;
  logic        o_busy;
  logic        o_load_done;
  logic        o_req_drop;
`ifdef FB_LOAD_CHECKSUM_EN
  logic [31:0] o_checksum;
`endif

  always #5 clk = ~clk;

  fb_loader dut (
    .clk            (clk),
    .rstn           (rstn),
    .q_channel      (q_channel),
    .q_filter_base  (q_filter_base),
    .i_load_req     (i_load_req),
    .i_chn_out      (i_chn_out),
    .o_rd_req_valid (o_rd_req_valid),
    .i_rd_req_ready (i_rd_req_ready),
    .o_rd_addr      (o_rd_addr),
    .i_rd_data_valid(i_rd_data_valid),
    .i_rd_data      (i_rd_data),
    .o_fb_we        (o_fb_we),
    .o_fb_addr      (o_fb_addr),
    .o_fb_wdata     (o_fb_wdata),
    .o_busy         (o_busy),
    .o_load_done    (o_load_done),
    .o_req_drop     (o_req_drop)
`ifdef FB_LOAD_CHECKSUM_EN
    ,
    .o_checksum     (o_checksum)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int lat     = 1;
  int rdy_mode = 0;        // 0: always ready, 1: ready on even cycles
  bit data_seq = 1'b0;     // memory returns 1,2,3.. relative to seq_base
  logic [23:0] seq_base = '0;

  int          ret_cyc[$];
  logic [23:0] ret_addr[$];
  logic [23:0] exp_addr_q[$];
  logic [9:0]  exp_fba_q[$];
  logic [31:0] exp_dat_q[$];

  bit          ld_active = 1'b0;
  bit          clr_next  = 1'b0;
  int          req_cyc   = 0;
  int          exp_tot   = 0;
  int          done_cnt  = 0;
  int          wr_cnt    = 0;
  bit          stall_prev = 1'b0;
  logic [23:0] stall_addr = '0;

  function automatic logic [31:0] mem_word(input logic [23:0] a);
    logic [23:0] d;
    if (data_seq) begin
      d = a - seq_base;
      return 32'(d) + 32'd1;
    end
    return 32'hA500_0000 ^ {8'h00, a};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock of memory model plus scoreboard, evaluated at the falling edge.
  task automatic step();
    int n_before;
    @(negedge clk);
    cyc++;
    if (clr_next) begin
      ld_active = 1'b0;
      clr_next  = 1'b0;
    end
    i_rd_req_ready = (rdy_mode == 0) ? 1'b1 : ((cyc % 2) == 0);
    n_before = ret_cyc.size();
    if (n_before > 0 && ret_cyc[0] == cyc) begin
      void'(ret_cyc.pop_front());
      i_rd_data       = mem_word(ret_addr.pop_front());
      i_rd_data_valid = 1'b1;
    end else begin
      i_rd_data       = '0;
      i_rd_data_valid = 1'b0;
    end
    if (stall_prev) begin
      chk("addr_hold_valid", 64'(o_rd_req_valid), 64'd1);
      chk("addr_hold", 64'(o_rd_addr), 64'(stall_addr));
    end
    stall_prev = o_rd_req_valid && !i_rd_req_ready;
    stall_addr = o_rd_addr;
    if (o_rd_req_valid && i_rd_req_ready) begin
      chk("outst_limit", 64'(n_before < MAX_OUTST), 64'd1);
      if (exp_addr_q.size() == 0) chk("rd_unexpected", 64'd1, 64'd0);
      else chk("rd_addr", 64'(o_rd_addr), 64'(exp_addr_q.pop_front()));
      ret_cyc.push_back(cyc + lat);
      ret_addr.push_back(o_rd_addr);
    end
    if (o_fb_we) begin
      wr_cnt++;
      if (exp_dat_q.size() == 0) chk("wr_unexpected", 64'd1, 64'd0);
      else begin
        chk("fb_addr", 64'(o_fb_addr), 64'(exp_fba_q.pop_front()));
        chk("fb_wdata", 64'(o_fb_wdata), 64'(exp_dat_q.pop_front()));
      end
    end
    if (o_load_done) begin
      done_cnt++;
      clr_next = 1'b1;
      chk("done_writes_left", 64'(exp_dat_q.size()), 64'd0);
    end
  endtask

  // Drive a one-cycle request; push expectations only if the bench's own
  // model says the loader is idle (not loading and not in the done cycle).
  task automatic issue(input logic [7:0] ch, input logic [23:0] base, input logic [7:0] chn);
    logic [11:0] tot;
    logic [23:0] b;
    q_channel     = ch;
    q_filter_base = base;
    i_chn_out     = chn;
    i_load_req    = 1'b1;
    if (!ld_active) begin
      tot = 12'(ch) * 12'd9;
      b   = base + 24'(chn) * 24'(tot);
      for (int i = 0; i < int'(tot); i++) begin
        exp_addr_q.push_back(b + 24'(i));
        exp_fba_q.push_back(10'(i));
        exp_dat_q.push_back(mem_word(b + 24'(i)));
      end
      ld_active = 1'b1;
      req_cyc   = cyc;
      exp_tot   = int'(tot);
    end
    step();
    i_load_req = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit chk_lat);
    int d0;
    int n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < budget) begin
      step();
      n++;
    end
    if (done_cnt == d0) chk("done_timeout", 64'd0, 64'd1);
    else if (chk_lat) chk("done_latency", 64'(cyc - req_cyc), 64'(exp_tot + 3));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d0;
    int w0;
    int n;
    rstn = 1'b0;
    q_channel = '0; q_filter_base = '0; i_load_req = 1'b0; i_chn_out = '0;
    i_rd_req_ready = 1'b0; i_rd_data_valid = 1'b0; i_rd_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_rd_valid", 64'(o_rd_req_valid), 64'd0);
    chk("rst_rd_addr", 64'(o_rd_addr), 64'd0);
    chk("rst_fb_we", 64'(o_fb_we), 64'd0);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_done", 64'(o_load_done), 64'd0);
    chk("rst_drop", 64'(o_req_drop), 64'd0);
    rstn = 1'b1;
    repeat (2) step();

    // Basic load: 18 words from 0x136, zero-wait memory.
    d0 = done_cnt; w0 = wr_cnt;
    issue(8'd2, 24'h000100, 8'd3);
    wait_done(100, 1'b1);
    step();
    chk("done_one_cycle", 64'(o_load_done), 64'd0);
    chk("basic_writes", 64'(wr_cnt - w0), 64'd18);
    chk("basic_done_cnt", 64'(done_cnt - d0), 64'd1);
    chk("basic_busy_clear", 64'(o_busy), 64'd0);

    // Backpressure: ready toggling, 6-cycle read latency.
    rdy_mode = 1; lat = 6;
    repeat (2) step();
    d0 = done_cnt; w0 = wr_cnt;
    issue(8'd2, 24'h000100, 8'd3);
    wait_done(400, 1'b0);
    repeat (3) step();
    chk("bp_writes", 64'(wr_cnt - w0), 64'd18);
    chk("bp_done_cnt", 64'(done_cnt - d0), 64'd1);
    rdy_mode = 0; lat = 1;
    repeat (8) step();

    // Overlap: drop mid-load and in the done cycle, accept one cycle later.
    d0 = done_cnt;
    chk("drop_before_overlap", 64'(o_req_drop), 64'd0);
    issue(8'd2, 24'h000400, 8'd1);
    repeat (4) step();
    issue(8'd2, 24'h000999, 8'd5);
    step();
    chk("req_drop_set", 64'(o_req_drop), 64'd1);
    wait_done(100, 1'b1);
    issue(8'd1, 24'h000777, 8'd2);   // lands in the done cycle
    issue(8'd1, 24'h000500, 8'd0);   // first cycle after done
    wait_done(100, 1'b1);
    step();
    chk("ovl_done_cnt", 64'(done_cnt - d0), 64'd2);
    chk("drop_sticky", 64'(o_req_drop), 64'd1);

    // Address wrap through 0xFFFFFF.
    issue(8'd1, 24'hFFFFF8, 8'd0);
    wait_done(100, 1'b1);
    repeat (2) step();

`ifdef FB_LOAD_CHECKSUM_EN
    data_seq = 1'b1; seq_base = 24'h000200;
    issue(8'd1, 24'h000200, 8'd0);
    wait_done(100, 1'b1);
    chk("checksum", 64'(o_checksum), 64'd45);
    step();
    issue(8'd1, 24'h000200, 8'd0);
    chk("checksum_clear", 64'(o_checksum), 64'd0);
    wait_done(100, 1'b1);
    data_seq = 1'b0;
    repeat (2) step();
`endif

    // Reset in the middle of a load, after the 7th write.
    w0 = wr_cnt;
    issue(8'd2, 24'h000100, 8'd3);
    n = 0;
    while (wr_cnt - w0 < 7 && n < 100) begin
      step();
      n++;
    end
    chk("rst_mid_reached", 64'(wr_cnt - w0), 64'd7);
    rstn = 1'b0;
    #1;
    chk("mid_rst_rd_valid", 64'(o_rd_req_valid), 64'd0);
    chk("mid_rst_rd_addr", 64'(o_rd_addr), 64'd0);
    chk("mid_rst_fb_we", 64'(o_fb_we), 64'd0);
    chk("mid_rst_fb_addr", 64'(o_fb_addr), 64'd0);
    chk("mid_rst_busy", 64'(o_busy), 64'd0);
    chk("mid_rst_done", 64'(o_load_done), 64'd0);
    chk("mid_rst_drop", 64'(o_req_drop), 64'd0);
    ret_cyc.delete(); ret_addr.delete();
    exp_addr_q.delete(); exp_fba_q.delete(); exp_dat_q.delete();
    ld_active = 1'b0; clr_next = 1'b0; stall_prev = 1'b0;
    i_rd_data_valid = 1'b0;
    d0 = done_cnt;
    repeat (3) step();
    rstn = 1'b1;
    repeat (25) step();
    chk("no_done_after_rst", 64'(done_cnt - d0), 64'd0);
    w0 = wr_cnt;
    issue(8'd2, 24'h000100, 8'd3);
    wait_done(100, 1'b1);
    chk("post_rst_writes", 64'(wr_cnt - w0), 64'd18);
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fb_loader.md
Name: fb_loader

Overview:
- Filter-buffer loader sitting directly upstream of the PE array and beside the CNN controller.
- On each filter-load request pulse, fetches the weight tile for one output-channel tile from external memory through a split address/data read interface, and writes it sequentially into the filter buffer SRAM.
- Signals completion with a one-cycle done pulse, which the PE uses to finish channel sync.

Parameters:
- W_CHANNEL, 8: width of tiled channel counts and indices.
- W_ADDR, 24: external memory word-address width.
- W_DATA, 32: memory and filter-buffer word width.
- W_FB_ADDR, 10: filter-buffer address width.
- K_WORDS, 9: words per input-channel tile per output-channel tile (3x3 kernel).
- MAX_OUTST, 4: maximum outstanding read requests; power of 2, at least 1.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- q_channel  in  W_CHANNEL  tiled input-channel count; 0 is illegal.
- q_filter_base  in  W_ADDR  layer weight base word address.
- i_load_req  in  1  single-cycle load request pulse.
- i_chn_out  in  W_CHANNEL  output-channel tile index to load; sampled with i_load_req.
- o_rd_req_valid  out  1  read address valid.
- i_rd_req_ready  in  1  read address accepted.
- o_rd_addr  out  W_ADDR  read word address.
- i_rd_data_valid  in  1  read data valid; no backpressure, in-order.
- i_rd_data  in  W_DATA  read data.
- o_fb_we  out  1  filter-buffer write enable.
- o_fb_addr  out  W_FB_ADDR  filter-buffer write address.
- o_fb_wdata  out  W_DATA  filter-buffer write data.
- o_busy  out  1  load in progress.
- o_load_done  out  1  single-cycle completion pulse.
- o_req_drop  out  1  sticky: a request arrived while busy.

Behaviour:
- Interface: reset rstn, asynchronous, active-low; clock clk. All outputs are registered.
- Reset values: all outputs 0, all counters 0, FSM in IDLE. Reset mid-load aborts immediately; no done pulse is issued.

Request capture (IDLE):
- i_load_req latches the following and moves the FSM to FETCH on the next cycle:
  - total = q_channel*K_WORDS, width W_CHANNEL+4, zero-extended.
  - base = q_filter_base + i_chn_out*total, computed mod 2^W_ADDR.
- total must be at most 2^W_FB_ADDR; the bench guarantees this.

FETCH state:
- Address issue:
  - o_rd_req_valid=1 while issued<total and outstanding<MAX_OUTST.
  - o_rd_addr = base+issued.
  - Handshake fires when valid and ready are both high in the same cycle; issued increments.
  - valid and addr stay stable until accepted.
- Data return:
  - Each i_rd_data_valid produces one write the next cycle: o_fb_we=1, o_fb_addr=received, o_fb_wdata=i_rd_data. received then increments.
- Outstanding counter:
  - +1 on request handshake, -1 on data beat; a simultaneous handshake and beat leave it unchanged.
  - A data beat arriving while outstanding==0 is ignored.
- Leave FETCH for DONE when received==total (the last write is issued that cycle).

DONE state:
- o_load_done=1 for exactly one cycle, then the FSM returns to IDLE.
- o_busy=1 in FETCH and DONE.

Request overlap rules:
- i_load_req while o_busy: request dropped, o_req_drop set. It is cleared only by reset.
- i_load_req in the cycle o_load_done is high: also dropped.
- A request is first accepted in the cycle after o_load_done.

Latency:
- Zero-wait memory with 1-cycle read latency: o_load_done rises total+3 cycles after i_load_req.

Optional Feature:
- FB_LOAD_CHECKSUM_EN defined:
  - Adds output o_checksum, width W_DATA: wrapping sum of all words written in the current load.
  - Cleared on request capture; valid when o_load_done is high; held until the next capture.
- Undefined: the port and adder are absent.

Decomposition:
- Shared package/header (controller_params.vh): W_CHANNEL, W_ADDR, W_DATA, W_FB_ADDR, K_WORDS defaults, and FSM state encodings FB_IDLE=0, FB_FETCH=1, FB_DONE=2.
- One sub-module, fb_rd_issue: address generator plus outstanding-credit counter. The top keeps the FSM, the receive/write path and the checksum.

Test Plan:
- Basic load: q_channel=2, base=0x100, chn_out=3, ready always 1, latency 1. Expect:
  - addresses 0x136..0x147, 18 writes to fb addr 0..17 with matching data;
  - o_load_done exactly 21 cycles after the request.
- Backpressure: ready toggles 1/0 with read latency 6, MAX_OUTST=4. Expect:
  - outstanding never exceeds 4;
  - o_rd_addr stable while valid and not ready;
  - 18 in-order writes, single done pulse.
- Overlap: second i_load_req 5 cycles into the load, and a third in the done cycle. Expect:
  - o_req_drop=1;
  - only one load executes; the next request, one cycle after done, starts normally.
- Reset mid-load: rstn low at write 7. Expect:
  - all outputs 0 immediately;
  - no done pulse;
  - a fresh request afterwards completes all 18 words.
- Wrap: q_filter_base=0xFFFFF8, chn_out=0, q_channel=1. Expect addresses 0xFFFFF8..0xFFFFFF, then 0x000000.
- Checksum (FB_LOAD_CHECKSUM_EN): data words 1..9 with q_channel=1. Expect o_checksum=45 at done; it is cleared on the next request.
